rv32i_fetch_buf: RTL and testbench

Instruction fetch stage directly upstream of the RV32I instruction decoder. It generates sequential fetch addresses, issues them on an in-order instruction-bus request/response interface, and buffers returned words in a DEPTH-entry queue. It presents one instruction word (ir) plus its PC to the decode stage under a valid/ready handshake. On a redirect from execute, it flushes the queue and discards any stale in-flight responses.

---
 rtl/rv32i_fetch_buf.sv | 146 ++++++++++++++
 tb/tb_rv32i_fetch_buf.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch_buf.sv
// RV32I fetch stage: issues sequential word fetches, queues in-order bus
// responses and hands instructions to decode; redirects flush and drop stale data.
module rv32i_fetch_buf #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_vld,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_vld,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  input  logic        redir_vld,
  input  logic [31:0] redir_pc,
  output logic        ir_vld,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_err
);
  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]      pc_q, pc_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0]    cnt_q, cnt_d, pend_q, pend_d, drop_q, drop_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [31:0]      epc_q [DEPTH];
  logic [31:0]      epc_d [DEPTH];
  logic [31:0]      edata_q [DEPTH];
  logic [31:0]      edata_d [DEPTH];
  logic [DEPTH-1:0] eerr_q, eerr_d;
  logic [31:0]      last_ir_q, last_ir_d, last_pc_q, last_pc_d;
  logic             last_err_q, last_err_d;
  logic [CW:0]      used;
  logic             req_fire, pop, rsp_fill, head_filled;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit counts only registered occupancy; a pop frees credit a cycle later.
  always_comb begin
    used        = {1'b0, cnt_q} + {1'b0, drop_q};
    req_vld     = !rst && !redir_vld && (used < (CW+1)'(DEPTH));
    req_addr    = pc_q & 32'hFFFF_FFFC;
    req_fire    = req_vld && req_ready;
    head_filled = filled_q[head_q];
    ir_vld      = head_filled && !redir_vld;
    pop         = ir_vld && ir_ready;
    rsp_fill    = rsp_vld && (drop_q == '0);
    ir          = last_ir_q;
    ir_pc       = last_pc_q;
    ir_err      = last_err_q;
    if (head_filled) begin
      ir     = eerr_q[head_q] ? NOP : edata_q[head_q];
      ir_pc  = epc_q[head_q];
      ir_err = eerr_q[head_q];
    end
  end

  always_comb begin
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    filled_d   = filled_q;
    epc_d      = epc_q;
    edata_d    = edata_q;
    eerr_d     = eerr_q;
    last_ir_d  = ir;
    last_pc_d  = ir_pc;
    last_err_d = ir_err;
    if (redir_vld) begin
      // Every unfilled entry becomes a stale request; an arriving response retires one.
      pc_d     = redir_pc & 32'hFFFF_FFFC;
      head_d   = '0;
      tail_d   = '0;
      fill_d   = '0;
      cnt_d    = '0;
      pend_d   = '0;
      filled_d = '0;
      drop_d   = drop_q + pend_q - CW'(rsp_vld);
    end else begin
      if (rsp_vld && (drop_q != '0)) drop_d = drop_q - 1'b1;
      if (rsp_fill) begin
        filled_d[fill_q] = 1'b1;
        edata_d[fill_q]  = rsp_data;
        eerr_d[fill_q]   = rsp_err;
        fill_d           = ptr_inc(fill_q);
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = ptr_inc(head_q);
      end
      if (req_fire) begin
        epc_d[tail_q] = req_addr;
        tail_d        = ptr_inc(tail_q);
        pc_d          = pc_q + 32'd4;
      end
      cnt_d  = cnt_q + CW'(req_fire) - CW'(pop);
      pend_d = pend_q + CW'(req_fire) - CW'(rsp_fill);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
      last_ir_q  <= '0;
      last_pc_q  <= '0;
      last_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      filled_q   <= filled_d;
      last_ir_q  <= last_ir_d;
      last_pc_q  <= last_pc_d;
      last_err_q <= last_err_d;
    end
  end

  // Entry payload is only meaningful while its filled bit is set.
  always_ff @(posedge clk) begin
    epc_q   <= epc_d;
    edata_q <= edata_d;
    eerr_q  <= eerr_d;
  end
endmodule

// File: tb/tb_rv32i_fetch_buf.sv
// Bench for rv32i_fetch_buf: in-order bus model plus an instruction-stream
// reference model (expected PC sequence per redirect epoch).
module tb_rv32i_fetch_buf;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk, rst;
  logic        req_vld, req_ready;
  logic [31:0] req_addr;
  logic        rsp_vld, rsp_err;
  logic [31:0] rsp_data;
  logic        redir_vld;
  logic [31:0] redir_pc;
  logic        ir_vld, ir_ready, ir_err;
  logic [31:0] ir, ir_pc;

  rv32i_fetch_buf #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .redir_vld(redir_vld), .redir_pc(redir_pc),
    .ir_vld(ir_vld), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc), .ir_err(ir_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ep;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] exp_q[$];
  int          filled, epoch;
  logic [31:0] next_pc;
  int          rdy_pct, irr_pct, rsp_pct;
  logic [31:0] err_addr;
  bit          err_rand;
  int          cyc;
  int          pop_cyc[$], acc_cyc[$];
  logic [31:0] pop_pc[$], pop_ir[$], acc_addr[$];
  logic        pop_err[$];
  int          n_checks, n_errors;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    return (a == err_addr) || (err_rand && (a[5:2] == 4'hB));
  endfunction

  function automatic bit roll(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic model_reset();
    bus_q.delete(); exp_q.delete();
    filled = 0; epoch++; next_pc = RESET_PC; cyc = 0;
    pop_cyc.delete(); acc_cyc.delete(); pop_pc.delete(); pop_ir.delete();
    pop_err.delete(); acc_addr.delete();
  endtask

  // One clock: drive at posedge+1, check and advance the model at negedge.
  task automatic cycle();
    int stale;
    bit exp_req, exp_irv, pop_m, acc_m;
    bus_t b;
    rsp_vld  = 1'b0;
    rsp_data = $urandom;
    rsp_err  = 1'b0;
    if (bus_q.size() > 0 && roll(rsp_pct)) begin
      rsp_vld  = 1'b1;
      rsp_data = mem_word(bus_q[0].addr);
      rsp_err  = is_err(bus_q[0].addr);
    end
    req_ready = roll(rdy_pct);
    ir_ready  = roll(irr_pct);
    @(negedge clk);
    stale = 0;
    foreach (bus_q[i]) if (bus_q[i].ep != epoch) stale++;
    exp_req = !redir_vld && (exp_q.size() + stale < DEPTH);
    exp_irv = !redir_vld && (filled > 0);
    n_checks++;
    if (req_vld !== exp_req) begin
      n_errors++;
      $display("FAIL req_vld cyc=%0d got=%b exp=%b", cyc, req_vld, exp_req);
    end
    n_checks++;
    if (ir_vld !== exp_irv) begin
      n_errors++;
      $display("FAIL ir_vld cyc=%0d got=%b exp=%b", cyc, ir_vld, exp_irv);
    end
    pop_m = exp_irv && ir_ready;
    acc_m = exp_req && req_ready;
    if (pop_m) begin
      n_checks++;
      if (ir_pc !== exp_q[0] || ir_err !== is_err(exp_q[0]) ||
          ir !== (is_err(exp_q[0]) ? NOP : mem_word(exp_q[0]))) begin
        n_errors++;
        $display("FAIL ir_word cyc=%0d got pc=%h ir=%h err=%b exp pc=%h ir=%h err=%b",
                 cyc, ir_pc, ir, ir_err, exp_q[0],
                 is_err(exp_q[0]) ? NOP : mem_word(exp_q[0]), is_err(exp_q[0]));
      end
      pop_cyc.push_back(cyc); pop_pc.push_back(ir_pc);
      pop_ir.push_back(ir);   pop_err.push_back(ir_err);
    end
    if (acc_m) begin
      n_checks++;
      if (req_addr !== next_pc) begin
        n_errors++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, req_addr, next_pc);
      end
      acc_cyc.push_back(cyc); acc_addr.push_back(req_addr);
    end
    if (rsp_vld) begin
      b = bus_q.pop_front();
      if (b.ep == epoch && !redir_vld) filled++;
    end
    if (redir_vld) begin
      epoch++;
      exp_q.delete();
      filled  = 0;
      next_pc = redir_pc & 32'hFFFF_FFFC;
    end else begin
      if (pop_m) begin
        void'(exp_q.pop_front());
        filled--;
      end
      if (acc_m) begin
        bus_q.push_back('{addr: next_pc, ep: epoch});
        exp_q.push_back(next_pc);
        next_pc += 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; redir_vld = 1'b0; redir_pc = '0;
    rsp_vld = 1'b0; req_ready = 1'b0; ir_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; redir_vld = 1'b0; redir_pc = '0; rsp_vld = 1'b0;
    rsp_data = '0; rsp_err = 1'b0; req_ready = 1'b1; ir_ready = 1'b1;
    #2;
    n_checks++;
    if (req_vld !== 1'b0 || ir_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_vld req_vld=%b ir_vld=%b exp 0 0", req_vld, ir_vld);
    end
    n_checks++;
    if (ir !== 32'h0 || ir_pc !== 32'h0 || ir_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ir ir=%h ir_pc=%h ir_err=%b exp 0", ir, ir_pc, ir_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    rdy_pct = 100; irr_pct = 100; rsp_pct = 100;
    repeat (8) cycle();
    n_checks++;
    if (pop_cyc.size() < 2 || pop_cyc[0] != 2 || pop_cyc[1] != 3 || pop_pc[1] !== 32'h4) begin
      n_errors++;
      $display("FAIL stream_latency pops=%0d first_cyc=%0d exp first ir at cycle 2 then 3",
               pop_cyc.size(), pop_cyc.size() > 0 ? pop_cyc[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_pct = 100; irr_pct = 0; rsp_pct = 100;
    repeat (6) cycle();
    n_checks++;
    if (acc_cyc.size() != 2) begin
      n_errors++;
      $display("FAIL bp_requests got=%0d exp=2", acc_cyc.size());
    end
    irr_pct = 100;
    repeat (4) cycle();
    n_checks++;
    if (acc_cyc.size() < 3 || pop_cyc.size() < 1 ||
        acc_cyc[2] != pop_cyc[0] + 1 || acc_addr[2] !== 32'h8) begin
      n_errors++;
      $display("FAIL bp_resume accs=%0d pops=%0d exp fetch of 0x8 one cycle after first pop",
               acc_cyc.size(), pop_cyc.size());
    end
  endtask

  task automatic test_redirect();
    do_reset();
    rdy_pct = 100; irr_pct = 100; rsp_pct = 0;
    repeat (2) cycle();
    redir_vld = 1'b1; redir_pc = 32'h0000_0102;
    cycle();
    redir_vld = 1'b0;
    rsp_pct = 100;
    repeat (8) cycle();
    n_checks++;
    if (acc_cyc.size() < 3 || acc_addr[2] !== 32'h100 || acc_cyc[2] != 4) begin
      n_errors++;
      $display("FAIL redir_fetch accs=%0d exp 0x100 fetched at cycle 4", acc_cyc.size());
    end
    n_checks++;
    if (pop_pc.size() < 1 || pop_pc[0] !== 32'h100) begin
      n_errors++;
      $display("FAIL redir_first_ir pops=%0d pc=%h exp=00000100", pop_pc.size(),
               pop_pc.size() > 0 ? pop_pc[0] : 32'hx);
    end
  endtask

  task automatic test_redir_rsp();
    do_reset();
    rdy_pct = 100; irr_pct = 100; rsp_pct = 0;
    cycle();
    rdy_pct = 0; rsp_pct = 100;
    redir_vld = 1'b1; redir_pc = 32'h0000_0200;
    cycle();
    redir_vld = 1'b0;
    rdy_pct = 100;
    repeat (5) cycle();
    n_checks++;
    if (acc_cyc.size() < 2 || acc_cyc[1] != 2 || acc_addr[1] !== 32'h200) begin
      n_errors++;
      $display("FAIL redir_rsp_fetch accs=%0d exp 0x200 fetched at cycle 2", acc_cyc.size());
    end
    n_checks++;
    if (pop_pc.size() < 1 || pop_pc[0] !== 32'h200) begin
      n_errors++;
      $display("FAIL redir_rsp_first_ir pops=%0d exp pc 00000200", pop_pc.size());
    end
  endtask

  task automatic test_err();
    bit found;
    do_reset();
    err_addr = 32'h8;
    rdy_pct = 100; irr_pct = 100; rsp_pct = 100;
    repeat (10) cycle();
    found = 1'b0;
    for (int i = 0; i + 1 < pop_pc.size(); i++) begin
      if (pop_pc[i] === 32'h8) begin
        found = 1'b1;
        n_checks++;
        if (pop_ir[i] !== NOP || pop_err[i] !== 1'b1) begin
          n_errors++;
          $display("FAIL err_entry ir=%h err=%b exp ir=00000013 err=1", pop_ir[i], pop_err[i]);
        end
        n_checks++;
        if (pop_pc[i+1] !== 32'hC || pop_err[i+1] !== 1'b0) begin
          n_errors++;
          $display("FAIL err_next pc=%h err=%b exp pc=0000000c err=0", pop_pc[i+1], pop_err[i+1]);
        end
      end
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL err_seen got=0 exp=1");
    end
    err_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rdy_pct = 100; irr_pct = 0; rsp_pct = 100;
    repeat (4) cycle();
    rst = 1'b1;
    #2;
    n_checks++;
    if (req_vld !== 1'b0 || ir_vld !== 1'b0 || ir_pc !== 32'h0) begin
      n_errors++;
      $display("FAIL mid_reset req_vld=%b ir_vld=%b ir_pc=%h exp 0 0 0", req_vld, ir_vld, ir_pc);
    end
    rsp_vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    irr_pct = 100;
    repeat (4) cycle();
    n_checks++;
    if (acc_addr.size() < 1 || acc_addr[0] !== RESET_PC || acc_cyc[0] != 0) begin
      n_errors++;
      $display("FAIL mid_reset_restart accs=%0d exp first fetch RESET_PC at cycle 0", acc_addr.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    err_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        rdy_pct = int'($urandom_range(100, 30));
        irr_pct = int'($urandom_range(100, 30));
        rsp_pct = int'($urandom_range(100, 30));
      end
      redir_vld = roll(4);
      redir_pc  = $urandom & 32'h0000_FFFF;
      cycle();
    end
    redir_vld = 1'b0;
    n_checks++;
    if (pop_pc.size() < 200) begin
      n_errors++;
      $display("FAIL random_progress pops=%0d exp>=200", pop_pc.size());
    end
    err_rand = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; epoch = 0; cyc = 0;
    err_addr = 32'hFFFF_FFFF; err_rand = 1'b0;
    rdy_pct = 100; irr_pct = 100; rsp_pct = 100;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redir_rsp();
    test_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
